// File: rtl/keyed_mux_lock.sv
// keyed_mux_lock: serially keyed bank of 1-of-2**KEY_W muxes with failed-attempt lockout
module keyed_mux_lock #(
  parameter int KEY_W = 2,
  parameter int CH = 1,
  parameter logic [2**KEY_W-1:0] ALLOW_MASK = 4'b0111,
  parameter int MAX_FAIL = 3
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic [CH*2**KEY_W-1:0]  din,
  input  logic                    key_start,
  input  logic                    key_in,
  input  logic                    key_vld,
  output logic [CH-1:0]           mux_o,
  output logic                    active,
  output logic                    fault,
  output logic                    lockout,
  output logic                    busy,
  output logic [3:0]              fail_cnt
);
  localparam int N = 2**KEY_W;
  localparam int KL = CH*KEY_W;
  localparam int CW = $clog2(KL+1);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ACTIVE, FAULT, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic [KL-1:0] key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] fail_q, fail_d;
  logic [CH-1:0] sel, mux_q, mux_d;
  logic key_ok;
  logic active_q, fault_q, lockout_q, busy_q;
  // per-channel field decode: allowed-code check and selected data bit
  always_comb begin
    key_ok = 1'b1;
    sel = '0;
    for (int c = 0; c < CH; c++) begin
      key_ok &= ALLOW_MASK[key_q[c*KEY_W +: KEY_W]];
      sel[c] = din[c*N + int'(key_q[c*KEY_W +: KEY_W])];
    end
  end
  // next-state, key shift register, bit counter and fail counter
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    cnt_d = cnt_q;
    fail_d = fail_q;
    case (state_q)
      IDLE, ACTIVE, FAULT: if (key_start) begin
        state_d = LOAD;
        key_d = '0;
        cnt_d = '0;
      end
      LOAD: if (key_start) begin
        key_d = '0;
        cnt_d = '0;
      end else if (key_vld) begin
        key_d = KL'({key_q, key_in});
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(KL-1)) ? CHECK : LOAD;
      end
      CHECK: if (key_ok) begin
        state_d = ACTIVE;
      end else begin
        fail_d = (fail_q == 4'(MAX_FAIL)) ? fail_q : fail_q + 4'd1;
        state_d = (fail_d == 4'(MAX_FAIL)) ? LOCKOUT : FAULT;
      end
      default: state_d = state_q;
    endcase
    mux_d = (state_q == ACTIVE && state_d == ACTIVE) ? sel : '0;
  end
  // state, key and registered output decodes
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      key_q <= '0;
      cnt_q <= '0;
      fail_q <= '0;
      mux_q <= '0;
      active_q <= 1'b0;
      fault_q <= 1'b0;
      lockout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
      fail_q <= fail_d;
      mux_q <= mux_d;
      active_q <= state_d == ACTIVE;
      fault_q <= state_d == FAULT;
      lockout_q <= state_d == LOCKOUT;
      busy_q <= state_d == LOAD || state_d == CHECK;
    end
  end
  assign mux_o = mux_q;
  assign active = active_q;
  assign fault = fault_q;
  assign lockout = lockout_q;
  assign busy = busy_q;
  assign fail_cnt = fail_q;
endmodule

// File: doc/keyed_mux_lock.md
Name: keyed_mux_lock

Overview:
- Sequential, parametrised successor to the key-controlled obfuscation mux inserted into our combinational benchmark netlists.
- Provides CH independent keyed multiplexers, each selecting 1 of 2**KEY_W data bits using a KEY_W-bit key field.
- The key is loaded serially and checked against a parameterised allowed-code set. The block tracks failed attempts and enters a lockout state after too many.
- Sits between primary inputs and the locked logic cone. Drives the net previously driven by the combinational mux.

Parameters:
KEY_W, 2, key bits per channel; each mux has 2**KEY_W data inputs
CH, 1, number of keyed mux channels
ALLOW_MASK, 4'b0111, bit k set means key code k is allowed (default allows 00,01,10); width 2**KEY_W
MAX_FAIL, 3, failed checks before permanent lockout (1..15)

Ports:
CK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
din  input  CH*2**KEY_W  data; channel c uses din[c*2**KEY_W +: 2**KEY_W]
key_start  input  1  begin a new key load
key_in  input  1  serial key bit
key_vld  input  1  key_in valid this cycle
mux_o  output  CH  registered mux outputs
active  output  1  key accepted, muxes live
fault  output  1  last check failed
lockout  output  1  fail limit reached
busy  output  1  in LOAD or CHECK
fail_cnt  output  4  failed-check count, saturating at MAX_FAIL

Behaviour:
- Reset (RN low, async): state IDLE, key register 0, bit counter 0, fail_cnt 0. All outputs 0.
- States: IDLE, LOAD, CHECK, ACTIVE, FAULT, LOCKOUT. Total key length is KL = CH*KEY_W.
- IDLE/ACTIVE/FAULT:
  - key_start=1 -> LOAD on the next edge; bit counter cleared; key register cleared.
  - Otherwise hold state.
- LOAD:
  - Each cycle with key_vld=1, key register shifts left and key_in enters at the LSB. After KL bits, the first bit sent sits at bit KL-1.
  - Counter increments on each valid bit. When the KL-th valid bit is accepted, go to CHECK on the next edge.
  - key_start=1 in LOAD restarts: counter and key cleared, stay in LOAD.
  - key_start has priority over key_vld in the same cycle; that key bit is dropped.
- CHECK (exactly 1 cycle): channel c field is key[c*KEY_W +: KEY_W].
  - Every field f has ALLOW_MASK[f]=1 -> ACTIVE; fail_cnt unchanged.
  - Otherwise fail_cnt increments (saturating). If the new count equals MAX_FAIL -> LOCKOUT, else -> FAULT.
- LOCKOUT: absorbing; key_start and key_vld ignored. Only RN exits it.
- key_vld outside LOAD: ignored.
- mux_o:
  - In ACTIVE, mux_o[c] is registered din[c*2**KEY_W + field_c], so din to mux_o latency is 1 cycle.
  - In every other state mux_o is forced to 0 on the next edge.
  - First live mux_o value appears the cycle after entry to ACTIVE.
- Status outputs are registered decodes of the state:
  - active=1 only in ACTIVE.
  - fault=1 only in FAULT.
  - lockout=1 only in LOCKOUT.
  - busy=1 in LOAD and CHECK.
- Reloading from ACTIVE drops mux_o to 0 for the entire reload, even if the new key equals the old one.
- Reset asserted mid-LOAD or mid-ACTIVE returns to the reset values immediately; no partial key is retained.

Test Plan:
- Default params: reset, key_start, send bits 1,0 with key_vld -> CHECK, then active=1. With din=4'b0100, mux_o=1 one cycle after ACTIVE entry. Changing din to 4'b0000 gives mux_o=0 one cycle later.
- Send key 1,1 (code 3 disallowed) -> fault=1, fail_cnt=1, mux_o=0. Repeat twice more -> after the third failure lockout=1, fail_cnt=3. A further key_start leaves lockout=1.
- key_vld with gaps (bit, idle 3 cycles, bit) -> CHECK occurs only after the 2nd valid bit. key_start together with key_vld mid-load -> counter restarts, and the next two valid bits form the key.
- CH=3, KEY_W=2: serial key 00_01_10 (first bit sent at MSB) -> channel 2 selects din bit 0, channel 1 bit 1, channel 0 bit 2. Each channel output matches its selected din bit.
- Assert RN in ACTIVE, and separately after 2 failures -> all outputs 0 and fail_cnt 0. A fresh valid key then reaches ACTIVE.
- ALLOW_MASK=4'b1000, key 11 -> active=1. Key 00 -> fault=1.
